// File: rtl/maj_adder_pkg.sv
// Shared definitions for the majority-gate multiword adder: slice width, sequencer states, maj3 primitive.
package maj_adder_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Three-input majority; the only logic primitive the slice is built from besides inverters.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/maj_slice4.sv
// Combinational 4-bit ripple adder built solely from majority gates and inverters.
module maj_slice4
    import maj_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic [SLICE_W:0] c;

    assign c[0] = ci;

    // Full adder per bit: carry = maj(a,b,c); sum = maj(~carry, c, maj(a,b,~c)).
    for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
        assign c[i+1] = maj3(a[i], b[i], c[i]);
        assign s[i]   = maj3(~c[i+1], c[i], maj3(a[i], b[i], ~c[i]));
    end

    assign co = c[SLICE_W];

endmodule

// File: rtl/multiword_adder_seq.sv
// Sequencer driving one maj_slice4 over WORDS slices, one slice per cycle, with valid/ready on both sides.
// Optional subtract mode when SUB_EN is defined (adds the sub input port).
module multiword_adder_seq
    import maj_adder_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SLICE_W*WORDS-1:0]   a,
    input  logic [SLICE_W*WORDS-1:0]   b,
    input  logic                       cin,
`ifdef SUB_EN
    input  logic                       sub,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W*WORDS-1:0]   sum,
    output logic                       cout
);

    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef logic [WORDS-1:0][SLICE_W-1:0] words_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry_q;
    words_t           a_q;
    words_t           b_q;
    words_t           sum_q;

    logic [SLICE_W-1:0] slice_a_c;
    logic [SLICE_W-1:0] slice_b_c;
    logic [SLICE_W-1:0] slice_s_c;
    logic               slice_co_c;
    logic               carry_init_c;

`ifdef SUB_EN
    logic sub_q;

    // Subtraction is a + ~b + 1: invert B slices and seed the carry with 1.
    assign slice_b_c    = sub_q ? ~b_q[idx] : b_q[idx];
    assign carry_init_c = sub ? 1'b1 : cin;
`else
    assign slice_b_c    = b_q[idx];
    assign carry_init_c = cin;
`endif

    assign slice_a_c = a_q[idx];

    maj_slice4 u_slice (
        .a  (slice_a_c),
        .b  (slice_b_c),
        .ci (carry_q),
        .s  (slice_s_c),
        .co (slice_co_c)
    );

    assign sum = sum_q;

    // Sequencer FSM; all handshake and result outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cout      <= 1'b0;
`ifdef SUB_EN
            sub_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry_q  <= carry_init_c;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
`ifdef SUB_EN
                        sub_q    <= sub;
`endif
                    end
                end
                RUN: begin
                    sum_q[idx] <= slice_s_c;
                    carry_q    <= slice_co_c;
                    if (idx == LAST_IDX) begin
                        cout      <= slice_co_c;
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    // Result held until the consumer takes it; no new accept from here.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Self-checking bench for multiword_adder_seq: directed cases plus random operations against an arithmetic model.
module tb_multiword_adder_seq;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 4 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SUB_EN
    logic         sub;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiword_adder_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain W+1-bit arithmetic; subtraction gives a-b mod 2^W with cout = no borrow.
    function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic c, input logic s);
        logic [W:0] r;
        if (s) begin
            r[W-1:0] = x - y;
            r[W]     = (x >= y);
        end else begin
            r = (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
        end
        return r;
    endfunction

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                          input logic tsub, input int hold, input string tag);
        logic [W:0] exp;
        int n;
        exp = ref_result(ta, tb_v, tcin, tsub);
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, " in_ready_idle"}, 64'(in_ready), 64'(1));
        a = ta;
        b = tb_v;
        cin = tcin;
`ifdef SUB_EN
        sub = tsub;
`endif
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
        n = 0;
        while (!out_valid && n < 50) begin
            check({tag, " in_ready_busy"}, 64'(in_ready), 64'(0));
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(WORDS));
        check({tag, " sum"}, 64'(sum), 64'(exp[W-1:0]));
        check({tag, " cout"}, 64'(cout), 64'(exp[W]));
        check({tag, " in_ready_done"}, 64'(in_ready), 64'(0));
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            a = W'($urandom);
            tick();
            check({tag, " hold_valid"}, 64'(out_valid), 64'(1));
            check({tag, " hold_sum"}, 64'(sum), 64'(exp[W-1:0]));
            check({tag, " hold_cout"}, 64'(cout), 64'(exp[W]));
            check({tag, " hold_in_ready"}, 64'(in_ready), 64'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid_drop"}, 64'(out_valid), 64'(0));
        check({tag, " in_ready_back"}, 64'(in_ready), 64'(1));
        check({tag, " sum_kept"}, 64'(sum), 64'(exp[W-1:0]));
    endtask

    initial begin
        int t_first;
        int t_second;
        int n;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rc;
        logic rs;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
`ifdef SUB_EN
        sub = 1'b0;
`endif
        #12;
        check("rst in_ready", 64'(in_ready), 64'(1));
        check("rst out_valid", 64'(out_valid), 64'(0));
        check("rst sum", 64'(sum), 64'(0));
        check("rst cout", 64'(cout), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "ffff_plus_1");
        run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 2, "1234_plus_4321");
        run_op(16'hA5A5, 16'h0F0F, 1'b0, 1'b0, 10, "hold10");

        // Reset while idx==2: operation discarded, no out_valid afterwards.
        a = 16'h1234;
        b = 16'h1111;
        cin = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrun_rst out_valid", 64'(out_valid), 64'(0));
        check("midrun_rst sum", 64'(sum), 64'(0));
        check("midrun_rst in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrun_rst no_valid", 64'(out_valid), 64'(0));
        end
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, "post_rst");

        // Continuous demand: one result every WORDS+2 cycles.
        a = 16'h0001;
        b = 16'h0002;
        cin = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        t_first = -1;
        t_second = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) begin
                check("tput sum", 64'(sum), 64'(3));
                check("tput in_ready", 64'(in_ready), 64'(0));
                if (t_first < 0) t_first = i;
                else if (t_second < 0) t_second = i;
            end
        end
        check("tput seen", 64'(t_second >= 0), 64'(1));
        check("tput period", 64'(t_second - t_first), 64'(WORDS + 2));
        in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("tput drain", 64'(in_ready), 64'(1));
        out_ready = 1'b0;

`ifdef SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, "sub_5_7");
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 1, "sub_7_5");
`endif

        for (int k = 0; k < 300; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, rc, rs, $urandom_range(0, 3), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
